rv_prefetch: RTL and testbench

RV_PREFETCH -- requirements
Module: rv_prefetch

---
 rtl/rv_fetch_pkg.sv | 17 +
 rtl/rv_fetch_fifo.sv | 46 ++++
 rtl/rv_prefetch.sv | 104 ++++++++++
 tb/tb_rv_prefetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage constants: canonical NOP encoding, register field positions, width helper.
package rv_fetch_pkg;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          REG_W   = 5;
  localparam int          RD_LSB  = 7;
  localparam int          RS1_LSB = 15;
  localparam int          RS2_LSB = 20;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO with flush (flush beats push/pop); a push is visible at the head next cycle.
// No internal full/empty guard: the owner never pushes when full nor pops when empty.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

// File: rtl/rv_prefetch.sv
// Credit-limited instruction prefetcher: buffered + in-flight never exceed DEPTH; head held on stall.
// Responses reach the head one cycle after arrival; redirects flush and drop stale in-flight words.
module rv_prefetch
  import rv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [31:0]      im_addr_o,
  output logic             im_req_o,
  input  logic [31:0]      im_data_i,
  input  logic             im_valid_i,
  input  logic             f_stall_i,
  input  logic             f_kill_i,
  input  logic             x_bra_i,
  input  logic [31:0]      x_pc_bra_i,
  output logic [31:0]      f_ir_o,
  output logic [31:0]      f_pc_o,
  output logic [31:0]      f_pc_plus_4_o,
  output logic             f_valid_o,
  output logic [REG_W-1:0] rf_rs1_o,
  output logic [REG_W-1:0] rf_rs2_o,
  output logic             f_load_hazard_o
);
  localparam int CW = clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [31:0]      fetch_pc;
  logic [CW-1:0]    ibuf_cnt;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt;
  logic [63:0]      ibuf_head;
  logic [31:0]      addr_head;
  logic             ibuf_nonempty;
  logic             push;
  logic             pop;
  logic             consume;
  logic             last_rd_vld;
  logic [REG_W-1:0] last_rd;

  assign im_addr_o     = x_bra_i ? x_pc_bra_i : fetch_pc;
  assign im_req_o      = !rst_i && ((SW'(ibuf_cnt) + SW'(outstanding)) < SW'(DEPTH));
  assign push          = im_valid_i && (drop_cnt == '0);
  assign ibuf_nonempty = (ibuf_cnt != '0);
  assign pop           = ibuf_nonempty && !f_stall_i;
  assign consume       = f_valid_o && !f_stall_i;

  // Address of every unanswered request, including those marked for dropping.
  rv_fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (1'b0),
    .push     (im_req_o),
    .push_dat (im_addr_o),
    .pop      (im_valid_i),
    .head_dat (addr_head),
    .count    (outstanding)
  );

  rv_fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_ibuf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (x_bra_i),
    .push     (push),
    .push_dat ({addr_head, im_data_i}),
    .pop      (pop),
    .head_dat (ibuf_head),
    .count    (ibuf_cnt)
  );

  assign f_valid_o       = ibuf_nonempty && !f_kill_i;
  assign f_ir_o          = ibuf_nonempty ? ibuf_head[31:0] : NOP;
  assign f_pc_o          = ibuf_head[63:32];
  assign f_pc_plus_4_o   = f_pc_o + 32'd4;
  assign rf_rs1_o        = f_ir_o[RS1_LSB +: REG_W];
  assign rf_rs2_o        = f_ir_o[RS2_LSB +: REG_W];
  assign f_load_hazard_o = f_valid_o && last_rd_vld &&
                           ((rf_rs1_o == last_rd) || (rf_rs2_o == last_rd));

  // A redirect with no credit still retargets fetch so the branch is never lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      drop_cnt    <= '0;
      last_rd_vld <= 1'b0;
      last_rd     <= '0;
    end else begin
      if (im_req_o)     fetch_pc <= im_addr_o + 32'd4;
      else if (x_bra_i) fetch_pc <= x_pc_bra_i;

      if (x_bra_i)                             drop_cnt <= outstanding - CW'(im_valid_i);
      else if (im_valid_i && drop_cnt != '0)   drop_cnt <= drop_cnt - CW'(1);

      if (x_bra_i) begin
        last_rd_vld <= 1'b0;
      end else if (consume) begin
        last_rd_vld <= 1'b1;
        last_rd     <= f_ir_o[RD_LSB +: REG_W];
      end
    end
  end
endmodule

// File: tb/tb_rv_prefetch.sv
// Randomised bench for rv_prefetch: in-order variable-latency memory plus a queue-level fetch model.
module tb_rv_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] im_addr_o;
  logic        im_req_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic        f_stall_i;
  logic        f_kill_i;
  logic        x_bra_i;
  logic [31:0] x_pc_bra_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic [31:0] f_pc_plus_4_o;
  logic        f_valid_o;
  logic [4:0]  rf_rs1_o;
  logic [4:0]  rf_rs2_o;
  logic        f_load_hazard_o;

  rv_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .im_addr_o       (im_addr_o),
    .im_req_o        (im_req_o),
    .im_data_i       (im_data_i),
    .im_valid_i      (im_valid_i),
    .f_stall_i       (f_stall_i),
    .f_kill_i        (f_kill_i),
    .x_bra_i         (x_bra_i),
    .x_pc_bra_i      (x_pc_bra_i),
    .f_ir_o          (f_ir_o),
    .f_pc_o          (f_pc_o),
    .f_pc_plus_4_o   (f_pc_plus_4_o),
    .f_valid_o       (f_valid_o),
    .rf_rs1_o        (rf_rs1_o),
    .rf_rs2_o        (rf_rs2_o),
    .f_load_hazard_o (f_load_hazard_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;

  req_t        pend[$];
  ent_t        buf_q[$];
  int          n_out, n_drop, cyc, lat_lo, lat_hi;
  logic [31:0] exp_pc, arch_pc;
  logic        rd_vld;
  logic [4:0]  last_rd;
  logic        obs_vld, obs_hz;
  logic [31:0] obs_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Instruction image: two fixed words for the hazard scenario, hashed small register fields elsewhere.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0000_0300) return 32'h0000_2283;
    if (a == 32'h0000_0304) return 32'h0002_8313;
    h = a * 32'h9E37_79B1;
    h[11:7]  = {3'b000, h[31:30]};
    h[19:15] = {3'b000, h[29:28]};
    h[24:20] = {3'b000, h[27:26]};
    return h;
  endfunction

  // One clock cycle, entered just after a falling edge and left at the next falling edge.
  task automatic step(input logic stall, input logic kill, input logic bra, input logic [31:0] tgt);
    logic        resp, req_m, vld_m, hz_m;
    logic [31:0] raddr, addr_m, hir;
    resp  = 1'b0;
    raddr = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      resp  = 1'b1;
      raddr = pend[0].addr;
      void'(pend.pop_front());
    end
    f_stall_i  = stall;
    f_kill_i   = kill;
    x_bra_i    = bra;
    x_pc_bra_i = tgt;
    im_valid_i = resp;
    im_data_i  = resp ? memfn(raddr) : $urandom;
    #1;
    obs_vld = f_valid_o;
    obs_pc  = f_pc_o;
    obs_hz  = f_load_hazard_o;
    req_m   = (buf_q.size() + n_out) < DEPTH;
    addr_m  = bra ? tgt : exp_pc;
    chk("im_req", 32'(im_req_o), 32'(req_m));
    if (req_m) chk("im_addr", im_addr_o, addr_m);
    vld_m = (buf_q.size() != 0) && !kill;
    chk("f_valid", 32'(f_valid_o), 32'(vld_m));
    hz_m = 1'b0;
    if (buf_q.size() != 0) begin
      hir = buf_q[0].ir;
      chk("f_pc", f_pc_o, buf_q[0].pc);
      chk("f_ir", f_ir_o, hir);
      chk("f_pc4", f_pc_plus_4_o, buf_q[0].pc + 32'd4);
      chk("rs1", 32'(rf_rs1_o), 32'(hir[19:15]));
      chk("rs2", 32'(rf_rs2_o), 32'(hir[24:20]));
      hz_m = vld_m && rd_vld && (hir[19:15] == last_rd || hir[24:20] == last_rd);
    end
    chk("hazard", 32'(f_load_hazard_o), 32'(hz_m));
    // Program order: every consumed head (killed or not) continues the sequential stream.
    if (!bra && buf_q.size() != 0 && !stall) begin
      chk("order", f_pc_o, arch_pc);
      arch_pc = arch_pc + 32'd4;
    end
    if (bra) rd_vld = 1'b0;
    else if (vld_m && !stall) begin
      last_rd = buf_q[0].ir[11:7];
      rd_vld  = 1'b1;
    end
    if (bra) begin
      buf_q.delete();
      n_drop  = n_out - int'(resp);
      arch_pc = tgt;
    end else begin
      if (buf_q.size() != 0 && !stall) void'(buf_q.pop_front());
      if (resp) begin
        if (n_drop > 0) n_drop--;
        else buf_q.push_back('{raddr, memfn(raddr)});
      end
    end
    n_out = n_out + int'(req_m) - int'(resp);
    if (req_m)    exp_pc = addr_m + 32'd4;
    else if (bra) exp_pc = tgt;
    if (im_req_o) pend.push_back('{im_addr_o, cyc + int'($urandom_range(lat_hi, lat_lo))});
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    rst_i      = 1'b1;
    f_stall_i  = 1'b0;
    f_kill_i   = 1'b0;
    x_bra_i    = 1'b0;
    x_pc_bra_i = '0;
    im_valid_i = 1'b0;
    im_data_i  = '0;
    #1;
    chk({tag, "_req"}, 32'(im_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(f_valid_o), 32'd0);
    chk({tag, "_hazard"}, 32'(f_load_hazard_o), 32'd0);
    chk({tag, "_ir"}, f_ir_o, 32'h0000_0013);
    pend.delete();
    buf_q.delete();
    n_out   = 0;
    n_drop  = 0;
    rd_vld  = 1'b0;
    last_rd = '0;
    exp_pc  = RESET_PC;
    arch_pc = RESET_PC;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk({tag, "_first_req"}, 32'(im_req_o), 32'd1);
    chk({tag, "_first_addr"}, im_addr_o, RESET_PC);
  endtask

  task automatic wait_head(input logic [31:0] exp, input logic stall, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(stall, 1'b0, 1'b0, 32'h0);
      if (obs_vld) begin
        seen = 1'b1;
        chk(tag, obs_pc, exp);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'(obs_vld), 32'd1);
  endtask

  task automatic run_random(input int n, input int lo, input int hi,
                            input int p_stall, input int p_kill, input int p_bra);
    logic [31:0] tgt;
    lat_lo = lo;
    lat_hi = hi;
    for (int i = 0; i < n; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(99, 0) < p_stall, $urandom_range(99, 0) < p_kill,
           $urandom_range(99, 0) < p_bra, tgt);
    end
  endtask

  initial begin
    cyc    = 0;
    lat_lo = 1;
    lat_hi = 1;
    do_reset("por");

    // 1-cycle memory, free-running consumer: first head valid in cycle 2 at RESET_PC.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c0_valid", 32'(obs_vld), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c1_valid", 32'(obs_vld), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c2_valid", 32'(obs_vld), 32'd1);
    chk("c2_pc", obs_pc, RESET_PC);
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);

    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_noreq", 32'(im_req_o), 32'd0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect in a cycle that also carries a response and a pop.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    wait_head(32'h0000_0200, 1'b0, "bra_pop");

    lat_lo = 3;
    lat_hi = 3;
    repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    wait_head(32'h0000_0100, 1'b0, "bra_lat3");

    lat_lo = 1;
    lat_hi = 1;
    step(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    wait_head(32'h0000_0300, 1'b0, "hz_rd_head");
    wait_head(32'h0000_0304, 1'b1, "hz_rs_head");
    chk("hz_rd5", 32'(obs_hz), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("kill_valid", 32'(obs_vld), 32'd0);
    chk("kill_hazard", 32'(obs_hz), 32'd0);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    wait_head(32'hFFFF_FFF8, 1'b0, "wrap_lo");
    wait_head(32'hFFFF_FFFC, 1'b0, "wrap_hi");
    wait_head(32'h0000_0000, 1'b0, "wrap_zero");

    lat_lo = 3;
    lat_hi = 3;
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset("mid");

    run_random(800, 1, 1, 20, 10, 3);
    run_random(800, 1, 4, 40, 10, 5);
    run_random(800, 2, 6, 10, 5, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
